prores_stage_sequencer: RTL and testbench

Parametrised per-slice timing sequencer for the entropy-coding back end. It replaces the free-running, hard-coded sequencer.
- Accepts a start pulse with a block count and runs one slice.
- Generates the release, output-enable and flush windows for the DC VLC and AC VLC stages, plus per-stage position counters.
- Returns a done pulse, then accepts the next slice.
- Sits between the slice controller and the DCT/quant/VLC pipeline.

---
 rtl/prores_stage_sequencer_pkg.sv | 38 +++
 rtl/prores_stage_sequencer_if.sv | 42 ++++
 rtl/prores_stage_sequencer_window.sv | 28 ++
 rtl/prores_stage_sequencer.sv | 178 +++++++++++++++++
 tb/tb_prores_stage_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/prores_stage_sequencer_pkg.sv
// Shared types and default latencies for the ProRes per-slice stage sequencer.
// Holds the FSM state encoding and the latched window-boundary record.
package prores_seq_pkg;

    localparam int unsigned SEQ_CNT_W      = 32;
    localparam int unsigned SEQ_BLK_W      = 16;
    localparam int unsigned SEQ_DCT_LAT    = 10;
    localparam int unsigned SEQ_DC_LAT     = 44;
    localparam int unsigned SEQ_DC_EN_OFS  = 7;
    localparam int unsigned SEQ_AC_EN_OFS  = 6;
    localparam int unsigned SEQ_AC_PER_BLK = 63;
    localparam int unsigned SEQ_TAIL_OFS   = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    typedef logic [SEQ_CNT_W-1:0] seq_cnt_t;

    // dc_base/ac_base double as the reset-release set points (T0+1, T1+1)
    typedef struct packed {
        seq_cnt_t dc_base;
        seq_cnt_t dc_rst_clr;
        seq_cnt_t dc_en_set;
        seq_cnt_t dc_en_clr;
        seq_cnt_t ac_base;
        seq_cnt_t ac_en_set;
        seq_cnt_t ac_en_clr;
        seq_cnt_t end_pt;
    } seq_bnd_t;

endpackage

// File: rtl/prores_stage_sequencer_if.sv
// Slice-controller <-> sequencer bundle. The abort line exists only when
// PRORES_SEQ_ABORT_EN is defined.
interface prores_stage_sequencer_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned BLK_W = 16
);
    logic             start;
    logic [BLK_W-1:0] block_num;
`ifdef PRORES_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sequence_counter;
    logic             dc_vlc_reset;
    logic             dc_vlc_output_enable;
    logic [CNT_W-1:0] dc_vlc_counter;
    logic             ac_vlc_reset;
    logic             ac_vlc_output_enable;
    logic             ac_vlc_output_flush;
    logic [CNT_W-1:0] ac_vlc_counter;

    modport master (
        output start, block_num,
`ifdef PRORES_SEQ_ABORT_EN
        output abort,
`endif
        input  busy, done, sequence_counter,
        input  dc_vlc_reset, dc_vlc_output_enable, dc_vlc_counter,
        input  ac_vlc_reset, ac_vlc_output_enable, ac_vlc_output_flush, ac_vlc_counter
    );

    modport slave (
        input  start, block_num,
`ifdef PRORES_SEQ_ABORT_EN
        input  abort,
`endif
        output busy, done, sequence_counter,
        output dc_vlc_reset, dc_vlc_output_enable, dc_vlc_counter,
        output ac_vlc_reset, ac_vlc_output_enable, ac_vlc_output_flush, ac_vlc_counter
    );
endinterface

// File: rtl/prores_stage_sequencer_window.sv
// Registered set/clear window keyed on the sequence counter; clear beats set
// when both points land on the same edge.
module prores_seq_window #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] seq,
    input  logic [CNT_W-1:0] set_pt,
    input  logic [CNT_W-1:0] clr_pt,
    input  logic             clear,
    output logic             level
);

    // Window level register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
        end else if (clear || (seq == clr_pt)) begin
            level <= 1'b0;
        end else if (seq == set_pt) begin
            level <= 1'b1;
        end else begin
            level <= level;
        end
    end

endmodule

// File: rtl/prores_stage_sequencer.sv
// Per-slice timing sequencer for the DC/AC VLC back end.
// Optional abort input is enabled by defining PRORES_SEQ_ABORT_EN.
module prores_stage_sequencer
    import prores_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = SEQ_CNT_W,
    parameter int unsigned BLK_W      = SEQ_BLK_W,
    parameter int unsigned DCT_LAT    = SEQ_DCT_LAT,
    parameter int unsigned DC_LAT     = SEQ_DC_LAT,
    parameter int unsigned DC_EN_OFS  = SEQ_DC_EN_OFS,
    parameter int unsigned AC_EN_OFS  = SEQ_AC_EN_OFS,
    parameter int unsigned AC_PER_BLK = SEQ_AC_PER_BLK,
    parameter int unsigned TAIL_OFS   = SEQ_TAIL_OFS
) (
    input logic                     clock,
    input logic                     reset_n,
    prores_stage_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [1:0]       state_r;
    logic             busy_r;
    logic             done_r;
    logic             flush_r;
    logic [CNT_W-1:0] seq_r;
    seq_bnd_t         bnd_r;
    seq_bnd_t         bnd_s;

    logic [CNT_W-1:0] n_s;
    logic [CNT_W-1:0] t0_s;
    logic [CNT_W-1:0] t1_s;
    logic [CNT_W-1:0] a_s;
    logic [CNT_W-1:0] e_s;
    logic             n_zero_s;
    logic             abort_s;
    logic             start_ok_s;
    logic             run_s;
    logic             win_clear_s;
    logic             flush_hit_s;
    logic             dc_rst_s;
    logic             dc_en_s;
    logic             ac_rst_s;
    logic             ac_en_s;

`ifdef PRORES_SEQ_ABORT_EN
    assign abort_s = bus.abort && (state_r == ST_RUN);
`else
    assign abort_s = 1'b0;
`endif

    assign n_s         = CNT_W'(bus.block_num);
    assign n_zero_s    = (bus.block_num == {BLK_W{1'b0}});
    // an abort request on the same cycle as start wins over the start
`ifdef PRORES_SEQ_ABORT_EN
    assign start_ok_s  = bus.start && !bus.abort;
`else
    assign start_ok_s  = bus.start;
`endif
    assign run_s       = (state_r == ST_RUN);
    assign win_clear_s = !run_s || abort_s;

    // Slice boundaries from the requested block count, modulo 2^CNT_W
    always_comb begin
        t0_s = CNT_W'(DCT_LAT) + n_s;
        t1_s = t0_s + CNT_W'(DC_LAT);
        a_s  = CNT_W'(AC_PER_BLK) * n_s;
        e_s  = t1_s + a_s + CNT_W'(TAIL_OFS);
        bnd_s            = {$bits(seq_bnd_t){1'b0}};
        bnd_s.dc_base    = SEQ_CNT_W'(t0_s + CNT_ONE);
        bnd_s.dc_rst_clr = SEQ_CNT_W'(t0_s + n_s + CNT_W'(4'd8));
        bnd_s.dc_en_set  = SEQ_CNT_W'(t0_s + CNT_W'(DC_EN_OFS));
        bnd_s.dc_en_clr  = SEQ_CNT_W'(t0_s + n_s + CNT_W'(DC_EN_OFS));
        bnd_s.ac_base    = SEQ_CNT_W'(t1_s + CNT_ONE);
        bnd_s.ac_en_set  = SEQ_CNT_W'(t1_s + CNT_W'(AC_EN_OFS));
        bnd_s.ac_en_clr  = SEQ_CNT_W'(t1_s + a_s + CNT_W'(AC_EN_OFS));
        bnd_s.end_pt     = SEQ_CNT_W'(e_s);
    end

    // Slice FSM: accept start, advance the sequence counter, pulse done
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            seq_r   <= {CNT_W{1'b0}};
            bnd_r   <= {$bits(seq_bnd_t){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_ok_s) begin
                        bnd_r  <= bnd_s;
                        busy_r <= 1'b1;
                        if (n_zero_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            seq_r   <= {CNT_W{1'b0}};
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    seq_r <= seq_r + CNT_ONE;
                    if (abort_s || (seq_r == CNT_W'(bnd_r.end_pt))) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // flush rides the falling edge of the AC enable window, never on abort
    assign flush_hit_s = run_s && !abort_s && ac_en_s &&
                         (seq_r == CNT_W'(bnd_r.ac_en_clr));

    // One-cycle AC bit-packer flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush_r <= 1'b0;
        end else begin
            flush_r <= flush_hit_s;
        end
    end

    prores_seq_window #(.CNT_W(CNT_W)) u_dc_rst (
        .clock(clock), .reset_n(reset_n), .seq(seq_r),
        .set_pt(CNT_W'(bnd_r.dc_base)), .clr_pt(CNT_W'(bnd_r.dc_rst_clr)),
        .clear(win_clear_s), .level(dc_rst_s)
    );

    prores_seq_window #(.CNT_W(CNT_W)) u_dc_en (
        .clock(clock), .reset_n(reset_n), .seq(seq_r),
        .set_pt(CNT_W'(bnd_r.dc_en_set)), .clr_pt(CNT_W'(bnd_r.dc_en_clr)),
        .clear(win_clear_s), .level(dc_en_s)
    );

    prores_seq_window #(.CNT_W(CNT_W)) u_ac_rst (
        .clock(clock), .reset_n(reset_n), .seq(seq_r),
        .set_pt(CNT_W'(bnd_r.ac_base)), .clr_pt(CNT_W'(bnd_r.end_pt)),
        .clear(win_clear_s), .level(ac_rst_s)
    );

    prores_seq_window #(.CNT_W(CNT_W)) u_ac_en (
        .clock(clock), .reset_n(reset_n), .seq(seq_r),
        .set_pt(CNT_W'(bnd_r.ac_en_set)), .clr_pt(CNT_W'(bnd_r.ac_en_clr)),
        .clear(win_clear_s), .level(ac_en_s)
    );

    assign bus.busy                 = busy_r;
    assign bus.done                 = done_r;
    assign bus.sequence_counter     = seq_r;
    assign bus.dc_vlc_reset         = dc_rst_s;
    assign bus.dc_vlc_output_enable = dc_en_s;
    assign bus.ac_vlc_reset         = ac_rst_s;
    assign bus.ac_vlc_output_enable = ac_en_s;
    assign bus.ac_vlc_output_flush  = flush_r;
    // bases reset to 0, so both counters read 0 while in reset
    assign bus.dc_vlc_counter       = seq_r - CNT_W'(bnd_r.dc_base);
    assign bus.ac_vlc_counter       = seq_r - CNT_W'(bnd_r.ac_base);

endmodule

// File: tb/tb_prores_stage_sequencer.sv
// Bench for prores_stage_sequencer: timeline reference model checked every
// cycle, plus a table of window levels at hand-computed sequence points.
module tb_prores_stage_sequencer;

    localparam int CW    = 32;
    localparam int BW    = 16;
    localparam int M_DCT = 10;
    localparam int M_DCL = 44;
    localparam int M_DCE = 7;
    localparam int M_ACE = 6;
    localparam int M_APB = 63;
    localparam int M_TL  = 8;
    localparam int NV    = 18;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    bit   abort_i = 1'b0;
    always #5 clock = ~clock;

    prores_stage_sequencer_if #(.CNT_W(CW), .BLK_W(BW)) bus ();
    prores_stage_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

`ifdef PRORES_SEQ_ABORT_EN
    assign bus.abort = abort_i;
`endif

    typedef struct {
        int         n;
        int         sq;
        logic [4:0] bits;   // {dc_rst, dc_en, ac_rst, ac_en, flush}
    } vec_t;
    vec_t vt [NV];

    int total = 0;
    int bad   = 0;

    // reference model: position inside the current slice timeline
    bit          m_act = 1'b0;
    int          m_c, m_end, m_n, t0, t1, aa, ee;
    logic [31:0] m_hold = 32'd0;
    logic [31:0] m_dcb  = 32'd0;
    logic [31:0] m_acb  = 32'd0;

    function automatic bit lvl(input int c, input int x, input int y);
        return (c - 1 >= x) && (c - 1 < y);
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_act = 1'b0; m_hold = 32'd0; m_dcb = 32'd0; m_acb = 32'd0;
        end else if (!m_act) begin
            if (bus.start && !abort_i) begin
                m_n   = int'(bus.block_num);
                t0    = M_DCT + m_n;
                t1    = t0 + M_DCL;
                aa    = M_APB * m_n;
                ee    = t1 + aa + M_TL;
                m_dcb = 32'(t0 + 1);
                m_acb = 32'(t1 + 1);
                m_act = 1'b1;
                m_c   = 0;
                m_end = (m_n == 0) ? 0 : ee + 1;
            end
        end else begin
            if (abort_i && m_c < m_end) m_end = m_c + 1;
            m_c++;
            if (m_c > m_end) m_act = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [6:0]  e_b;
        logic [6:0]  g_b;
        logic [4:0]  g_w;
        logic [31:0] e_dcc, e_acc;
        e_b = 7'd0;
        if (m_act && m_n > 0) m_hold = 32'(m_c);
        if (m_act) begin
            e_b[6] = 1'b1;
            e_b[5] = (m_c == m_end);
            if (m_n > 0 && m_c < m_end) begin
                e_b[4] = lvl(m_c, t0 + 1, t0 + m_n + 8);
                e_b[3] = lvl(m_c, t0 + M_DCE, t0 + m_n + M_DCE);
                e_b[2] = lvl(m_c, t1 + 1, ee);
                e_b[1] = lvl(m_c, t1 + M_ACE, t1 + aa + M_ACE);
                e_b[0] = (m_c == t1 + aa + M_ACE + 1);
            end
        end
        e_dcc = m_hold - m_dcb;
        e_acc = m_hold - m_acb;
        g_w = {bus.dc_vlc_reset, bus.dc_vlc_output_enable, bus.ac_vlc_reset,
               bus.ac_vlc_output_enable, bus.ac_vlc_output_flush};
        g_b = {bus.busy, bus.done, g_w};
        total++;
        if ({g_b, bus.sequence_counter, bus.dc_vlc_counter, bus.ac_vlc_counter} !==
            {e_b, m_hold, e_dcc, e_acc}) begin
            bad++;
            $display("FAIL cyc n=%0d c=%0d actual=%b/%0d/%h/%h required=%b/%0d/%h/%h",
                     m_n, m_c, g_b, bus.sequence_counter, bus.dc_vlc_counter,
                     bus.ac_vlc_counter, e_b, m_hold, e_dcc, e_acc);
        end
        for (int i = 0; i < NV; i++) begin
            if (m_act && m_n == vt[i].n && m_c == vt[i].sq && m_c < m_end) begin
                total++;
                if (g_w !== vt[i].bits) begin
                    bad++;
                    $display("FAIL tbl n=%0d seq=%0d actual=%b required=%b",
                             vt[i].n, vt[i].sq, g_w, vt[i].bits);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic expect_bit(input string nm, input logic got, input logic req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", nm, got, req);
        end
    endtask

    // one slice from an idle cycle; poke/rst/abrt < 0 disables that event
    task automatic run_slice(input int n, input int poke_at, input int rst_at, input int abrt_at);
        int guard;
        guard = 0;
        bus.start = 1'b1;
        bus.block_num = BW'(n);
        step();
        bus.start = 1'b0;
        bus.block_num = BW'($urandom);
        while (m_act && guard < 2000) begin
            if (m_c == poke_at) begin
                bus.start = 1'b1;
                bus.block_num = BW'($urandom_range(1, 9));
            end
            if (m_c == abrt_at) abort_i = 1'b1;
            if (m_c == rst_at) begin
                #2 reset_n = 1'b0;
                #1 expect_bit("async_rst", |{bus.busy, bus.done, bus.dc_vlc_reset,
                              bus.dc_vlc_output_enable, bus.ac_vlc_reset,
                              bus.ac_vlc_output_enable, bus.ac_vlc_output_flush,
                              bus.sequence_counter, bus.dc_vlc_counter,
                              bus.ac_vlc_counter}, 1'b0);
                model_edge();
                step();
                reset_n = 1'b1;
                step();
                return;
            end
            step();
            bus.start = 1'b0;
            abort_i   = 1'b0;
            guard++;
        end
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL timeout n=%0d actual=%0d required<2000", n, guard);
        end
    endtask

    initial begin
        vt[0]  = '{4, 15,  5'b00000};
        vt[1]  = '{4, 16,  5'b10000};
        vt[2]  = '{4, 22,  5'b11000};
        vt[3]  = '{4, 25,  5'b11000};
        vt[4]  = '{4, 26,  5'b10000};
        vt[5]  = '{4, 27,  5'b00000};
        vt[6]  = '{4, 59,  5'b00000};
        vt[7]  = '{4, 60,  5'b00100};
        vt[8]  = '{4, 65,  5'b00110};
        vt[9]  = '{4, 316, 5'b00110};
        vt[10] = '{4, 317, 5'b00101};
        vt[11] = '{4, 318, 5'b00100};
        vt[12] = '{1, 19,  5'b11000};
        vt[13] = '{1, 20,  5'b10000};
        vt[14] = '{1, 62,  5'b00110};
        vt[15] = '{1, 124, 5'b00110};
        vt[16] = '{1, 125, 5'b00101};
        vt[17] = '{2, 190, 5'b00100};

        bus.start = 1'b0;
        bus.block_num = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        run_slice(4, 100, -1, -1);
        run_slice(1, -1, -1, -1);
        step();

        // N=0: done on the very next cycle, then idle again
        bus.start = 1'b1;
        bus.block_num = '0;
        step();
        bus.start = 1'b0;
        expect_bit("n0_done", bus.done, 1'b1);
        expect_bit("n0_busy", bus.busy, 1'b1);
        step();
        expect_bit("n0_done_drop", bus.done, 1'b0);

        run_slice(4, -1, 200, -1);
        run_slice(2, -1, -1, -1);

`ifdef PRORES_SEQ_ABORT_EN
        run_slice(4, -1, -1, 100);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        step();
        expect_bit("abort_idle_busy", bus.busy, 1'b0);
`endif

        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) step();
            run_slice(int'($urandom_range(0, 5)), int'($urandom_range(0, 400)), -1, -1);
        end
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
